// File: rtl/multi_flex_counter_if.sv
// multi_flex_counter_if: per-channel control and status bundle for multi_flex_counter.
// Channel k occupies bits [k*NUM_CNT_BITS +: NUM_CNT_BITS] of every packed value bus.
interface multi_flex_counter_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS-1:0]              clear;
    logic [NUM_CHANNELS-1:0]              load;
    logic [NUM_CHANNELS-1:0]              count_enable;
    logic [NUM_CHANNELS-1:0]              up_down;
    logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CHANNELS-1:0]              rollover_flag;
    logic [NUM_CHANNELS-1:0]              wrap_pulse;

    modport master (
        output clear, load, count_enable, up_down, load_val, rollover_val,
        input  count_out, rollover_flag, wrap_pulse
    );

    modport slave (
        input  clear, load, count_enable, up_down, load_val, rollover_val,
        output count_out, rollover_flag, wrap_pulse
    );
endinterface

// File: rtl/multi_flex_counter.sv
// multi_flex_counter: NUM_CHANNELS up/down rollover counters; define MULTI_FLEX_COUNTER_CASCADE_EN to chain them.
// Latency: clear/load/count appear on count_out, rollover_flag and wrap_pulse one clk after sampling.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.
module multi_flex_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_flex_counter_if.slave  bus
);
    localparam int W = NUM_CNT_BITS;

    logic [W-1:0]            count_q [NUM_CHANNELS];
    logic [W-1:0]            count_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] flag_q;
    logic [NUM_CHANNELS-1:0] flag_d;
    logic [NUM_CHANNELS-1:0] wrap_q;
    logic [NUM_CHANNELS-1:0] wrap_d;

    always_comb begin
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
        // Wrap of the lower channel ripples into the next channel's enable within the cycle.
        logic carry;
        carry = 1'b1;
`endif
        flag_d = '0;
        wrap_d = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            logic [W-1:0] cur;
            logic [W-1:0] rv;
            logic [W-1:0] term;
            logic [W-1:0] nxt;
            logic         en;
            logic         wrap;

            cur  = count_q[k];
            rv   = bus.rollover_val[k*W +: W];
            term = bus.up_down[k] ? rv : W'(1);
            en   = bus.count_enable[k];
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
            en    = en & carry;
`endif
            wrap = en & (cur == term) & ~bus.clear[k] & ~bus.load[k];
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
            carry = wrap;
`endif
            if (bus.clear[k]) begin
                nxt = '0;
            end else if (bus.load[k]) begin
                nxt = bus.load_val[k*W +: W];
            end else if (en) begin
                // Up counts past a lowered rollover_val wrap naturally through 2^W-1 -> 0.
                if (bus.up_down[k]) begin
                    nxt = (cur == rv) ? W'(1) : cur + W'(1);
                end else begin
                    nxt = (cur <= W'(1)) ? rv : cur - W'(1);
                end
            end else begin
                nxt = cur;
            end

            count_d[k] = nxt;
            flag_d[k]  = (nxt == term);
            wrap_d[k]  = wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                count_q[k] <= '0;
            end
            flag_q <= '0;
            wrap_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                count_q[k] <= count_d[k];
            end
            flag_q <= flag_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_out
        assign bus.count_out[k*W +: W] = count_q[k];
    end
    assign bus.rollover_flag = flag_q;
    assign bus.wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_multi_flex_counter.sv
// Scoreboard bench for multi_flex_counter: stimulus pushes model predictions, a monitor pops and compares.
// The integer reference model follows MULTI_FLEX_COUNTER_CASCADE_EN the same way the build does.
module tb_multi_flex_counter;
    localparam int W = 4;
    localparam int C = 2;

    typedef struct {
        logic [C*W-1:0] cnt;
        logic [C-1:0]   flag;
        logic [C-1:0]   wrap;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   m_cnt [C];
    exp_t sb_q [$];

    multi_flex_counter_if #(.NUM_CNT_BITS(W), .NUM_CHANNELS(C)) bus ();

    multi_flex_counter #(.NUM_CNT_BITS(W), .NUM_CHANNELS(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic straight from the counting rules.
    task automatic model_push();
        exp_t e;
        bit   carry;
        carry = 1'b1;
        for (int k = 0; k < C; k++) begin
            int rvk, lvk, t, nxt;
            bit en, wrp, clr, ld, up;
            rvk = int'(bus.rollover_val[k*W +: W]);
            lvk = int'(bus.load_val[k*W +: W]);
            clr = bus.clear[k];
            ld  = bus.load[k];
            up  = bus.up_down[k];
            t   = up ? rvk : 1;
            en  = bus.count_enable[k];
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
            en  = en && carry;
`endif
            wrp   = en && (m_cnt[k] == t) && !clr && !ld;
            carry = wrp;
            if (clr)      nxt = 0;
            else if (ld)  nxt = lvk;
            else if (en) begin
                if (up)   nxt = (m_cnt[k] == rvk) ? 1 : (m_cnt[k] + 1) % (1 << W);
                else      nxt = (m_cnt[k] <= 1) ? rvk : m_cnt[k] - 1;
            end else      nxt = m_cnt[k];
            if (rst) begin
                nxt = 0;
                e.flag[k] = 1'b0;
                e.wrap[k] = 1'b0;
            end else begin
                e.flag[k] = (nxt == t);
                e.wrap[k] = wrp;
            end
            e.cnt[k*W +: W] = W'(nxt);
            m_cnt[k] = nxt;
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [C-1:0] clr, input logic [C-1:0] ld, input logic [C-1:0] en,
                        input logic [C-1:0] ud, input logic [C*W-1:0] lv, input logic [C*W-1:0] rv);
        @(negedge clk);
        bus.clear        = clr;
        bus.load         = ld;
        bus.count_enable = en;
        bus.up_down      = ud;
        bus.load_val     = lv;
        bus.rollover_val = rv;
        model_push();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus.count_out), 32'h0);
        chk("async_rst_flag", 32'(bus.rollover_flag), 32'h0);
        chk("async_rst_wrap", 32'(bus.wrap_pulse), 32'h0);
        step('0, '0, '0, '0, '0, '0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("count_out", 32'(bus.count_out), 32'(e.cnt));
                chk("rollover_flag", 32'(bus.rollover_flag), 32'(e.flag));
                chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(e.wrap));
            end
        end
    end

    initial begin : stimulus
        logic [C-1:0]   r_clr, r_ld, r_en, r_ud;
        logic [C*W-1:0] r_lv, r_rv;
        logic [C*W-1:0] casc_exp;
        checks = 0;
        errors = 0;
        for (int k = 0; k < C; k++) m_cnt[k] = 0;
        rst = 1'b1;
        bus.clear = '0; bus.load = '0; bus.count_enable = '0;
        bus.up_down = '0; bus.load_val = '0; bus.rollover_val = '0;
        #2;
        chk("reset_count", 32'(bus.count_out), 32'h0);
        chk("reset_flag", 32'(bus.rollover_flag), 32'h0);
        chk("reset_wrap", 32'(bus.wrap_pulse), 32'h0);
        step('0, '0, '0, '0, '0, 8'h45);
        rst = 1'b0;

        // ch0 up to 5 with enable held
        for (int i = 0; i < 8; i++) step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h45);
        // ch0 down, rollover 3, load 2 then count
        step(2'b00, 2'b01, 2'b00, 2'b00, 8'h02, 8'h43);
        for (int i = 0; i < 6; i++) step(2'b00, 2'b00, 2'b01, 2'b00, 8'h02, 8'h43);
        // priority: clear beats load beats count, then count past a lowered rollover
        step(2'b00, 2'b01, 2'b00, 2'b01, 8'h04, 8'h45);
        step(2'b01, 2'b01, 2'b01, 2'b01, 8'h07, 8'h45);
        step(2'b00, 2'b01, 2'b00, 2'b01, 8'h07, 8'h45);
        for (int i = 0; i < 12; i++) step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h43);
        // enable dropped while at the terminal value
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 2'b00, 2'b01, 8'h00, 8'h43);
        // async reset mid-count at 6
        step(2'b00, 2'b01, 2'b00, 2'b01, 8'h05, 8'h49);
        step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h49);
        pulse_reset();
        for (int i = 0; i < 2; i++) step(2'b00, 2'b00, 2'b01, 2'b01, 8'h00, 8'h49);
        // two channels, different rollovers and directions, disturbing clears/loads
        for (int i = 0; i < 20; i++) begin
            r_clr = {1'b0, (i % 5 == 2)};
            r_ld  = {(i % 7 == 3), 1'b0};
            step(r_clr, r_ld, 2'b11, 2'b01, 8'h20, 8'h43);
        end
        // cascade chain check from reset: 9 enabled cycles with rollover 3 on both
        pulse_reset();
        for (int i = 0; i < 9; i++) step(2'b00, 2'b00, 2'b11, 2'b11, 8'h00, 8'h33);
        @(posedge clk);
        #2;
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
        casc_exp = 8'h23;
`else
        casc_exp = 8'h33;
`endif
        chk("nine_cycle_count", 32'(bus.count_out), 32'(casc_exp));

        // randomized traffic
        r_ud = 2'b11;
        r_rv = 8'h35;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < C; k++) begin
                r_clr[k] = ($urandom % 16) == 0;
                r_ld[k]  = ($urandom % 16) == 0;
                r_en[k]  = ($urandom % 4) != 0;
                if (($urandom % 8) == 0)  r_ud[k] = ~r_ud[k];
                if (($urandom % 32) == 0) r_rv[k*W +: W] = W'($urandom % 16);
                r_lv[k*W +: W] = W'($urandom % 16);
            end
            step(r_clr, r_ld, r_en, r_ud, r_lv, r_rv);
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_flex_counter.md
# multi_flex_counter

Multi-channel, parametrised successor to the team's single rollover counter. It provides NUM_CHANNELS independent counters of NUM_CNT_BITS each. Every channel has its own rollover value, up/down direction, synchronous load and clear. It serves as the shared timing and event-counting resource for the bit-timing, byte-counting and timeout logic in the datapath. An optional cascade mode chains the channels into one wide prescaler/counter.

## Interface

- NUM_CNT_BITS, 4, width of each channel counter (≥2)
- NUM_CHANNELS, 2, number of independent channels (≥1)

Reset is asynchronous and active-high. All other inputs are synchronous to clk. Channel k occupies bits [k*NUM_CNT_BITS +: NUM_CNT_BITS] of each packed bus.

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- clear  input  NUM_CHANNELS  per-channel synchronous clear
- load  input  NUM_CHANNELS  per-channel synchronous load of load_val
- count_enable  input  NUM_CHANNELS  per-channel count enable
- up_down  input  NUM_CHANNELS  1 = count up, 0 = count down
- load_val  input  NUM_CHANNELS*NUM_CNT_BITS  per-channel load value
- rollover_val  input  NUM_CHANNELS*NUM_CNT_BITS  per-channel terminal value for up counting
- count_out  output  NUM_CHANNELS*NUM_CNT_BITS  per-channel registered count
- rollover_flag  output  NUM_CHANNELS  registered; high while the channel sits at its terminal value
- wrap_pulse  output  NUM_CHANNELS  registered; one-cycle pulse in the cycle after a channel wraps

## Operation

- Terminal value T[k]:
  - up mode: rollover_val[k]
  - down mode: 1
- Per-channel next-state priority, evaluated each cycle:
  1. clear[k] → next count 0
  2. else load[k] → next count load_val[k]
  3. else effective enable en[k]:
     - up mode, count == rollover_val → next count 1; otherwise count + 1, modulo 2^NUM_CNT_BITS
     - down mode, count ≤ 1 → next count rollover_val; otherwise count − 1
  4. else hold
- Wrap event: en[k] and count_out[k] == T[k] and no clear/load on channel k. This registers wrap_pulse[k] = 1 next cycle.
- rollover_flag[k] registers (next count == T[k]) under the current up_down[k]. It therefore rises in the same cycle count_out reaches T[k].
- Channels are fully independent unless cascade mode is compiled in (see Configuration).
- Counting past rollover_val is legal: if rollover_val is lowered below the current count, an up count keeps incrementing, wraps 2^N−1 → 0, and continues until it matches.
- rollover_val = 0, up mode: the sequence is 0,1,…,2^N−1,0. The flag is high when the count is 0 (except during reset). No 0→1 shortcut is taken.
- Changing up_down mid-count takes effect on the next enabled cycle with no other side effects.

## Timing

- Reset: count_out = 0, rollover_flag = 0, wrap_pulse = 0 on every channel, immediately and asynchronously. Counting resumes on the first rising edge after rst deasserts.
- clear, load and count each update count_out one clock after the input is sampled. Latency is 1 cycle.
- rollover_flag and wrap_pulse are aligned with the count_out value that produced them. Neither is combinational from the inputs.
- Up-mode wrap latency: count_out goes rollover_val → 1 on the next enabled edge. wrap_pulse is high for exactly one cycle, coincident with count_out = 1.
- Simultaneous events:
  - clear beats load, and load beats count. No wrap_pulse is generated.
  - rst asserted mid-count overrides everything in the same cycle.
- Enable deasserted at the terminal value: the count holds, rollover_flag stays high, and wrap_pulse stays 0.

## Configuration

- MULTI_FLEX_COUNTER_CASCADE_EN
  - Defined: en[0] = count_enable[0]. For k > 0, en[k] = count_enable[k] AND the wrap event of channel k−1 in the same cycle (combinational ripple within one cycle). The channels then form a mixed-radix counter, with channel 0 least significant.
  - Undefined: en[k] = count_enable[k] for all k, and no inter-channel logic is synthesised.
- clear, load and up_down stay per-channel in both builds.

## Test plan

- Reset/up count, N=4, rollover_val=5, enable held: count_out goes 0,1,2,3,4,5,1,2. Flag is high only at 5. wrap_pulse is high only on the cycle showing 1 after 5.
- Down count, rollover_val=3, load 2 then enable: count_out goes 2,1,3,2,1,3. Flag is high at each 1. wrap_pulse is high on each cycle showing 3 after 1.
- Priority: clear=1, load=1 (load_val=7), enable=1 at count 4 → next count 0 with no wrap_pulse. Then load alone → 7. Then rollover_val=3 in up mode → 8,9,…,15,0,1,2,3, flag at 3.
- Async reset mid-count at count 6: outputs are 0 before the next clk edge. After release, counting restarts 0,1.
- Independence (cascade undefined), 2 channels at different rollover values (3, 4) and directions: each channel follows its own sequence, unaffected by the other's clear or load.
- Cascade defined, rollover_val = 3 on both, all enabled: channel 1 increments only on cycles where channel 0 shows 1 after 3. After 9 enabled cycles from reset: ch0 = 3, ch1 = 2.
